// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel SRAM write path.
package sobel_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        FLUSH    = 3'd2,
        DONE_WR  = 3'd3,
        COMPLETE = 3'd4
    } wr_state_e;

    localparam int    DEPTH_DEF     = 4;
    localparam addr_t DONE_ADDR_DEF = 32'd4;
    localparam word_t DONE_WORD_DEF = 32'd1;
    localparam int    ENTRY_W       = 64;

    // FIFO entries carry the address in the upper half, data in the lower half.
    function automatic logic [ENTRY_W-1:0] pack_entry(input addr_t addr, input word_t data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO; head entry is presented combinationally on rdata.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: pop needs data, push needs room unless a pop frees a slot.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
        push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/sram_write_ctrl.sv
// SRAM write controller: grants words from the output buffer, queues them and writes them out.
// Optional word-write statistics output enabled by defining SRAM_WR_STATS_EN.
module sram_write_ctrl
    import sobel_pkg::*;
#(
    parameter int    DEPTH     = DEPTH_DEF,
    parameter addr_t DONE_ADDR = DONE_ADDR_DEF,
    parameter word_t DONE_WORD = DONE_WORD_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        word_ready,
    input  logic        word_strobe,
    input  logic [31:0] word_data,
    input  logic [31:0] word_addr,
    input  logic        img_done,
    output logic        write_out_enable,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_busy,
`ifdef SRAM_WR_STATS_EN
    output logic [15:0] words_written,
`endif
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wr_state_e          state_r;
    wr_state_e          state_s;
    logic               pending_r;
    logic               done_seen_r;
    logic               done_r;
    logic               grant_s;
    logic               push_s;
    logic               pop_s;
    logic               wr_en_s;
    addr_t              addr_s;
    word_t              wdata_s;
    logic [ENTRY_W-1:0] fifo_wdata_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign fifo_wdata_s = pack_entry(word_addr, word_data);
    assign push_s       = word_strobe && pending_r;

    // Grant only when the word is guaranteed a FIFO slot, counting the outstanding grant.
    always_comb begin
        grant_s = 1'b0;
        if (word_ready && !pending_r && !done_seen_r && !fifo_full_s &&
            ((fifo_count_s + {{AW{1'b0}}, pending_r}) < CW'(DEPTH))) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Outstanding-grant flag: set by a grant, cleared by the matching strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending_r <= 1'b0;
        end else if (push_s) begin
            pending_r <= 1'b0;
        end else if (grant_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Sticky image-done latch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_seen_r <= 1'b0;
        end else begin
            done_seen_r <= done_seen_r | img_done;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (done_seen_r)        state_s = FLUSH;
                else if (!fifo_empty_s) state_s = WRITE;
                else                    state_s = IDLE;
            end
            WRITE: begin
                if (done_seen_r)       state_s = FLUSH;
                else if (fifo_empty_s) state_s = IDLE;
                else                   state_s = WRITE;
            end
            FLUSH: begin
                if (fifo_empty_s && !pending_r) state_s = DONE_WR;
                else                            state_s = FLUSH;
            end
            DONE_WR: begin
                if (!mem_busy) state_s = COMPLETE;
                else           state_s = DONE_WR;
            end
            COMPLETE: state_s = COMPLETE;
            default:  state_s = IDLE;
        endcase
    end

    // Head entry drives the SRAM port in data states; the completion word once drained.
    always_comb begin
        wr_en_s = 1'b0;
        addr_s  = 32'd0;
        wdata_s = 32'd0;
        pop_s   = 1'b0;
        case (state_r)
            IDLE, WRITE, FLUSH: begin
                if (!fifo_empty_s) begin
                    wr_en_s = 1'b1;
                    addr_s  = fifo_rdata_s[ENTRY_W-1:32];
                    wdata_s = fifo_rdata_s[31:0];
                    pop_s   = !mem_busy;
                end else begin
                    wr_en_s = 1'b0;
                    pop_s   = 1'b0;
                end
            end
            DONE_WR: begin
                wr_en_s = 1'b1;
                addr_s  = DONE_ADDR;
                wdata_s = DONE_WORD;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // State and completion-flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == COMPLETE);
        end
    end

`ifdef SRAM_WR_STATS_EN
    logic [15:0] words_written_r;

    // Saturating count of accepted data writes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            words_written_r <= 16'd0;
        end else if (pop_s && (words_written_r != 16'hFFFF)) begin
            words_written_r <= words_written_r + 16'd1;
        end else begin
            words_written_r <= words_written_r;
        end
    end

    assign words_written = words_written_r;
`endif

    assign write_out_enable = grant_s;
    assign mem_wr_en        = wr_en_s;
    assign mem_addr         = addr_s;
    assign mem_wdata        = wdata_s;
    assign done             = done_r;

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Scoreboard bench for sram_write_ctrl: stimulus queues expected SRAM writes, a monitor checks them.
module tb_sram_write_ctrl;
    import sobel_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        word_ready;
    logic        word_strobe;
    logic [31:0] word_data;
    logic [31:0] word_addr;
    logic        img_done;
    logic        write_out_enable;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        done;
`ifdef SRAM_WR_STATS_EN
    logic [15:0] words_written;
`endif

    always #5 clk = ~clk;

    sram_write_ctrl dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .word_ready       (word_ready),
        .word_strobe      (word_strobe),
        .word_data        (word_data),
        .word_addr        (word_addr),
        .img_done         (img_done),
        .write_out_enable (write_out_enable),
        .mem_wr_en        (mem_wr_en),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_busy         (mem_busy),
`ifdef SRAM_WR_STATS_EN
        .words_written    (words_written),
`endif
        .done             (done)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_mem [0:63];
    int          exp_wr   = 0;
    int          exp_rd   = 0;
    int          flush_to = 0;

    logic [31:0] src_data [0:31];
    logic [31:0] src_addr [0:31];
    int          src_wr = 0;
    int          src_rd = 0;
    logic        gnt_prev = 1'b0;
    int          gnt_total = 0;
    logic        busy_cfg = 1'b0;
    logic        img_cfg = 1'b0;
    logic        rogue = 1'b0;

    // Monitor: checks every accepted write against the scoreboard and holds under busy.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] prev_data;
        prev_hold = 1'b0;
        prev_addr = 32'd0;
        prev_data = 32'd0;
        forever begin
            @(negedge clk);
            if (exp_rd < flush_to) exp_rd = flush_to;
            if (!n_rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (!mem_wr_en || mem_addr != prev_addr || mem_wdata != prev_data) begin
                        errors++;
                        $display("FAIL hold_stable: got en=%0b addr=%h data=%h, want en=1 addr=%h data=%h",
                                 mem_wr_en, mem_addr, mem_wdata, prev_addr, prev_data);
                    end
                end
                if (mem_wr_en && !mem_busy) begin
                    checks++;
                    if (exp_rd >= exp_wr) begin
                        errors++;
                        $display("FAIL unexpected_write: got addr=%h data=%h, want no write", mem_addr, mem_wdata);
                    end else begin
                        if ({mem_addr, mem_wdata} != exp_mem[exp_rd]) begin
                            errors++;
                            $display("FAIL write_order: got addr=%h data=%h, want addr=%h data=%h",
                                     mem_addr, mem_wdata, exp_mem[exp_rd][63:32], exp_mem[exp_rd][31:0]);
                        end
                        exp_rd++;
                    end
                end
                prev_hold = mem_wr_en && mem_busy;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic add_word(input logic [31:0] d, input logic [31:0] a);
        src_data[src_wr] = d;
        src_addr[src_wr] = a;
        src_wr++;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_mem[exp_wr] = {a, d};
        exp_wr++;
    endtask

    // One clock of upstream-buffer behaviour; returns just after the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        mem_busy = busy_cfg;
        img_done = img_cfg;
        if (gnt_prev) begin
            word_strobe = 1'b1;
            word_data   = src_data[src_rd];
            word_addr   = src_addr[src_rd];
            push_exp(src_addr[src_rd], src_data[src_rd]);
            src_rd++;
        end else if (rogue) begin
            word_strobe = 1'b1;
            word_data   = 32'hDEAD_BEEF;
            word_addr   = 32'h0000_0200;
            rogue       = 1'b0;
        end else begin
            word_strobe = 1'b0;
            word_data   = 32'd0;
            word_addr   = 32'd0;
        end
        word_ready = (src_rd < src_wr);
        @(negedge clk);
        gnt_prev = write_out_enable;
        if (write_out_enable) gnt_total++;
        #1;
    endtask

    task automatic drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((exp_rd != exp_wr || src_rd != src_wr || gnt_prev) && n < maxc) begin
            cycle();
            n++;
        end
        check(name, (n < maxc), 1'b1);
    endtask

    initial begin
        int   base;
        int   seen;
        int   run;
        int   n;
        int   bad;
        logic acc_prev;

        n_rst       = 1'b0;
        word_ready  = 1'b0;
        word_strobe = 1'b0;
        word_data   = 32'd0;
        word_addr   = 32'd0;
        img_done    = 1'b0;
        mem_busy    = 1'b0;

        @(negedge clk);
        #1;
        check("rst_grant", write_out_enable, 1'b0);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Single word: grant, strobe, write one cycle after capture.
        add_word(32'hF0F0_0001, 32'h0000_0100);
        cycle();
        check("t1_grant", gnt_prev, 1'b1);
        cycle();
        check("t1_no_early_write", mem_wr_en, 1'b0);
        cycle();
        check("t1_wr_en", mem_wr_en, 1'b1);
        check("t1_addr", mem_addr, 32'h0000_0100);
        check("t1_data", mem_wdata, 32'hF0F0_0001);
        cycle();
        check("t1_popped", mem_wr_en, 1'b0);
        check("t1_grants", gnt_total, 1);

        // Stray strobe without a grant is ignored.
        rogue = 1'b1;
        seen  = 0;
        repeat (4) begin
            cycle();
            if (mem_wr_en) seen++;
        end
        check("t2_stray_ignored", seen, 0);

        // Push and pop in the same cycle with two entries queued.
        base     = gnt_total;
        busy_cfg = 1'b1;
        add_word(32'h0000_00A1, 32'h0000_0010);
        add_word(32'h0000_00A2, 32'h0000_0014);
        add_word(32'h0000_00A3, 32'h0000_0018);
        n = 0;
        while ((gnt_total - base) < 3 && n < 20) begin
            cycle();
            n++;
        end
        check("t3_grants", gnt_total - base, 3);
        busy_cfg = 1'b0;
        run = 0;
        repeat (5) begin
            cycle();
            if (mem_wr_en) run++;
        end
        check("t3_run_len", run, 3);
        check("t3_all_written", exp_rd, exp_wr);

        // Backpressure: six words offered while busy, only DEPTH granted.
        base     = gnt_total;
        busy_cfg = 1'b1;
        for (int i = 0; i < 6; i++) add_word(32'hB000_0001 + i, 32'h0000_0200 + 4 * i);
        repeat (10) cycle();
        check("t4_grants_full", gnt_total - base, 4);
        check("t4_head_addr", mem_addr, 32'h0000_0200);
        busy_cfg = 1'b0;
        run = 0;
        repeat (4) begin
            cycle();
            if (mem_wr_en) run++;
        end
        check("t4_burst", run, 4);
        drain("t4_drain", 40);
`ifdef SRAM_WR_STATS_EN
        check("stats_count", words_written, 16'd10);
`endif

        // Reset with three words queued.
        busy_cfg = 1'b1;
        for (int i = 0; i < 3; i++) add_word(32'hC000_0001 + i, 32'h0000_0300 + 4 * i);
        repeat (8) cycle();
        check("t5_queued", mem_wr_en, 1'b1);
        @(posedge clk);
        #1;
        n_rst       = 1'b0;
        flush_to    = exp_wr;
        gnt_prev    = 1'b0;
        src_rd      = src_wr;
        word_ready  = 1'b0;
        word_strobe = 1'b0;
        busy_cfg    = 1'b0;
        mem_busy    = 1'b0;
        #1;
        check("t5_rst_wr_en", mem_wr_en, 1'b0);
        check("t5_rst_addr", mem_addr, 32'd0);
        check("t5_rst_wdata", mem_wdata, 32'd0);
        check("t5_rst_grant", write_out_enable, 1'b0);
`ifdef SRAM_WR_STATS_EN
        check("t5_rst_stats", words_written, 16'd0);
`endif
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        seen  = 0;
        repeat (6) begin
            cycle();
            if (mem_wr_en) seen++;
        end
        check("t5_no_stale", seen, 0);

        // Image done with three queued words: drain, completion word, sticky done.
        busy_cfg = 1'b1;
        for (int i = 0; i < 3; i++) add_word(32'hD000_0001 + i, 32'h0000_0400 + 4 * i);
        repeat (7) cycle();
        base    = gnt_total;
        img_cfg = 1'b1;
        cycle();
        img_cfg = 1'b0;
        push_exp(32'd4, 32'd1);
        add_word(32'hE000_0001, 32'h0000_0500);
        add_word(32'hE000_0002, 32'h0000_0504);
        repeat (4) cycle();
        check("t6_no_grant_after_done", gnt_total - base, 0);
        check("t6_done_early", done, 1'b0);
        busy_cfg = 1'b0;
        acc_prev = 1'b0;
        n = 0;
        while (n < 30) begin
            cycle();
            n++;
            if (done) break;
            acc_prev = mem_wr_en && !mem_busy && (mem_addr == 32'd4);
        end
        check("t6_done", done, 1'b1);
        check("t6_done_after_accept", acc_prev, 1'b1);
        bad = 0;
        repeat (5) begin
            cycle();
            if (!done || mem_wr_en || write_out_enable) bad++;
        end
        check("t6_done_sticky", bad, 0);
        check("t6_all_written", exp_rd, exp_wr);
        check("t6_grants_total", gnt_total - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
